// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the three-port SDRAM arbiter and its refresh timer.
package sdram_arb_pkg;

    localparam int NPORTS = 3;

    typedef logic [1:0] port_idx_t;

    localparam port_idx_t PORT_VIDEO = 2'd0;
    localparam port_idx_t PORT_IOCTL = 2'd1;
    localparam port_idx_t PORT_CPU   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RFSH   = 2'd2
    } state_t;

    function automatic logic [NPORTS-1:0] port_onehot(input port_idx_t idx);
        return NPORTS'(1) << idx;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter; raises a single pending flag on each wrap
// until the arbiter consumes it with clr.
module sdram_refresh_timer #(
    parameter int RFSH_INTERVAL = 1560
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic clr,
    output logic pending
);

    localparam int CW = (RFSH_INTERVAL > 1) ? $clog2(RFSH_INTERVAL) : 1;

    logic [CW-1:0] count;
    logic          wrap;

    assign wrap = (count == CW'(RFSH_INTERVAL - 1));

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // A wrap wins over clr so a refresh is never lost; the flag saturates at one.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
        end else if (wrap) begin
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-port SDRAM command arbiter: refresh first, then video, then ioctl/CPU
// round-robin; one outstanding command at a time.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW            = 24,
    parameter int RFSH_INTERVAL = 1560
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [NPORTS-1:0]    p_req,
    input  logic [NPORTS-1:0]    p_we,
    input  logic [NPORTS*AW-1:0] p_addr,
    input  logic [NPORTS*16-1:0] p_din,
    input  logic [NPORTS*2-1:0]  p_be,
    output logic [NPORTS-1:0]    p_ack,
    output logic [15:0]          p_dout,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_rfsh,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [15:0]          mem_din,
    output logic [1:0]           mem_be,
    input  logic                 mem_ack,
    input  logic [15:0]          mem_dout
);

    state_t    state, next_state;
    port_idx_t grant, sel, rr_last;
    logic      can_eval;
    logic      issue_req, issue_rfsh, finish;
    logic      rfsh_pending, rfsh_clr;

    sdram_refresh_timer #(
        .RFSH_INTERVAL (RFSH_INTERVAL)
    ) u_refresh_timer (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clr     (rfsh_clr),
        .pending (rfsh_pending)
    );

    // While p_ack is out the requester may not have dropped p_req yet, so hold off.
    assign can_eval = mem_ready && (p_ack == '0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first; a path that leaves one
    // unassigned would infer a latch.
    always_comb begin
        next_state = state;
        sel        = grant;
        issue_req  = 1'b0;
        issue_rfsh = 1'b0;
        rfsh_clr   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (can_eval) begin
                    if (rfsh_pending) begin
                        issue_rfsh = 1'b1;
                        rfsh_clr   = 1'b1;
                        next_state = RFSH;
                    end else if (p_req[PORT_VIDEO]) begin
                        sel        = PORT_VIDEO;
                        issue_req  = 1'b1;
                        next_state = ACCESS;
                    end else if (p_req[PORT_IOCTL] && (!p_req[PORT_CPU] || rr_last == PORT_CPU)) begin
                        sel        = PORT_IOCTL;
                        issue_req  = 1'b1;
                        next_state = ACCESS;
                    end else if (p_req[PORT_CPU]) begin
                        sel        = PORT_CPU;
                        issue_req  = 1'b1;
                        next_state = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            RFSH: begin
                if (mem_ack) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command fields are captured at grant time so the requester can change
    // its inputs freely while the access is in flight.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            grant    <= PORT_VIDEO;
            rr_last  <= PORT_CPU;
            mem_req  <= 1'b0;
            mem_rfsh <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_be   <= '0;
            p_ack    <= '0;
            p_dout   <= '0;
        end else begin
            mem_req  <= issue_req;
            mem_rfsh <= issue_rfsh;
            p_ack    <= finish ? port_onehot(grant) : '0;
            if (issue_req) begin
                grant    <= sel;
                mem_we   <= p_we[sel];
                mem_addr <= p_addr[int'(sel)*AW +: AW];
                mem_din  <= p_din[int'(sel)*16 +: 16];
                mem_be   <= p_be[int'(sel)*2 +: 2];
                if (sel != PORT_VIDEO) begin
                    rr_last <= sel;
                end
            end
            if (finish) begin
                p_dout <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a main instance for port traffic and a
// short-interval instance for periodic refresh.
module tb_sdram_arbiter;

    localparam int AW = 24;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic [2:0]    a_p_req, a_p_we, a_p_ack;
    logic [3*AW-1:0] a_p_addr;
    logic [47:0]   a_p_din;
    logic [5:0]    a_p_be;
    logic [15:0]   a_p_dout, a_mem_din, a_mem_dout;
    logic          a_mem_ready, a_mem_req, a_mem_rfsh, a_mem_we, a_mem_ack;
    logic [AW-1:0] a_mem_addr;
    logic [1:0]    a_mem_be;

    logic [2:0]    b_p_req, b_p_we, b_p_ack;
    logic [3*AW-1:0] b_p_addr;
    logic [47:0]   b_p_din;
    logic [5:0]    b_p_be;
    logic [15:0]   b_p_dout, b_mem_din, b_mem_dout;
    logic          b_mem_ready, b_mem_req, b_mem_rfsh, b_mem_we, b_mem_ack;
    logic [AW-1:0] b_mem_addr;
    logic [1:0]    b_mem_be;

    int n_checks = 0;
    int n_errors = 0;

    sdram_arbiter #(.AW(AW), .RFSH_INTERVAL(64)) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .p_req(a_p_req), .p_we(a_p_we), .p_addr(a_p_addr), .p_din(a_p_din), .p_be(a_p_be),
        .p_ack(a_p_ack), .p_dout(a_p_dout),
        .mem_ready(a_mem_ready), .mem_req(a_mem_req), .mem_rfsh(a_mem_rfsh),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_be(a_mem_be),
        .mem_ack(a_mem_ack), .mem_dout(a_mem_dout)
    );

    sdram_arbiter #(.AW(AW), .RFSH_INTERVAL(8)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .p_req(b_p_req), .p_we(b_p_we), .p_addr(b_p_addr), .p_din(b_p_din), .p_be(b_p_be),
        .p_ack(b_p_ack), .p_dout(b_p_dout),
        .mem_ready(b_mem_ready), .mem_req(b_mem_req), .mem_rfsh(b_mem_rfsh),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_be(b_mem_be),
        .mem_ack(b_mem_ack), .mem_dout(b_mem_dout)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic set_port(input int p, input logic we, input logic [AW-1:0] addr,
                            input logic [15:0] din, input logic [1:0] be);
        a_p_we[p]            = we;
        a_p_addr[p*AW +: AW] = addr;
        a_p_din[p*16 +: 16]  = din;
        a_p_be[p*2 +: 2]     = be;
    endtask

    task automatic do_reset(input string tag);
        reset_n     = 1'b0;
        a_p_req     = '0;
        a_mem_ack   = 1'b0;
        a_mem_ready = 1'b1;
        b_mem_ack   = 1'b0;
        tick(2);
        check({tag, "_rst_mem"}, {a_mem_req, a_mem_rfsh, a_mem_we, a_mem_be}, 0);
        check({tag, "_rst_addr"}, {8'h0, a_mem_addr}, 0);
        check({tag, "_rst_din"}, {16'h0, a_mem_din}, 0);
        check({tag, "_rst_pack"}, {a_p_ack, a_p_dout}, 0);
        reset_n = 1'b1;
    endtask

    // Wait for the next command, then complete it; port 3 denotes a refresh.
    task automatic serve(input string tag, input int exp_port, input logic [AW-1:0] exp_addr,
                         input logic [15:0] rd, input logic drop);
        int waited = 0;
        while (a_mem_req !== 1'b1 && a_mem_rfsh !== 1'b1 && waited < 40) begin
            tick(1);
            waited++;
        end
        check({tag, "_seen"}, {31'b0, a_mem_req | a_mem_rfsh}, 1);
        if (exp_port == 3) begin
            check({tag, "_kind"}, {a_mem_rfsh, a_mem_req}, 2'b10);
            tick(1);
            a_mem_ack = 1'b1;
            tick(1);
            a_mem_ack = 1'b0;
            check({tag, "_noack"}, a_p_ack, 0);
        end else begin
            check({tag, "_kind"}, {a_mem_rfsh, a_mem_req}, 2'b01);
            check({tag, "_addr"}, a_mem_addr, exp_addr);
            a_mem_ack  = 1'b1;
            a_mem_dout = rd;
            tick(1);
            a_mem_ack = 1'b0;
            check({tag, "_pack"}, a_p_ack, 3'b001 << exp_port);
            check({tag, "_dout"}, a_p_dout, rd);
            if (drop) a_p_req[exp_port] = 1'b0;
        end
    endtask

    initial begin
        int first_rfsh, last_rfsh, n_rfsh, n_req, n_both;
        logic b_prev;

        a_p_req = '0; a_p_we = '0; a_p_addr = '0; a_p_din = '0; a_p_be = '0;
        a_mem_ready = 1'b1; a_mem_ack = 1'b0; a_mem_dout = '0;
        b_p_req = '0; b_p_we = '0; b_p_addr = '0; b_p_din = '0; b_p_be = '0;
        b_mem_ready = 1'b1; b_mem_ack = 1'b0; b_mem_dout = '0;

        // Port 0 read with a slow controller.
        do_reset("rd0");
        set_port(0, 1'b0, 24'h000100, 16'h0000, 2'b11);
        a_p_req[0] = 1'b1;
        check("rd0_pre_req", {31'b0, a_mem_req}, 0);
        tick(1);
        check("rd0_req", {a_mem_rfsh, a_mem_req, a_mem_we}, 3'b010);
        check("rd0_addr", a_mem_addr, 24'h000100);
        tick(1);
        check("rd0_req_pulse", {31'b0, a_mem_req}, 0);
        tick(2);
        check("rd0_no_early_ack", a_p_ack, 0);
        a_mem_ack  = 1'b1;
        a_mem_dout = 16'hBEEF;
        tick(1);
        a_mem_ack = 1'b0;
        check("rd0_pack", a_p_ack, 3'b001);
        check("rd0_dout", a_p_dout, 16'hBEEF);
        a_p_req[0] = 1'b0;
        tick(1);
        check("rd0_pack_pulse", a_p_ack, 0);

        // Ports 1 and 2 competing: round-robin.
        do_reset("rr");
        set_port(1, 1'b0, 24'h000020, 16'h0, 2'b11);
        set_port(2, 1'b0, 24'h000030, 16'h0, 2'b11);
        a_p_req = 3'b110;
        serve("rr_1a", 1, 24'h000020, 16'h1001, 1'b0);
        serve("rr_2a", 2, 24'h000030, 16'h2001, 1'b0);
        serve("rr_1b", 1, 24'h000020, 16'h1002, 1'b0);
        serve("rr_2b", 2, 24'h000030, 16'h2002, 1'b1);
        a_p_req = '0;

        // Everyone at once with a refresh pending (mem_ready held low until it sets).
        do_reset("all");
        a_mem_ready = 1'b0;
        set_port(0, 1'b0, 24'h000010, 16'h0, 2'b11);
        set_port(1, 1'b0, 24'h000020, 16'h0, 2'b11);
        set_port(2, 1'b0, 24'h000030, 16'h0, 2'b11);
        a_p_req = 3'b111;
        tick(70);
        check("all_blocked", {a_mem_req, a_mem_rfsh}, 0);
        a_mem_ready = 1'b1;
        serve("all_rf", 3, '0, '0, 1'b0);
        serve("all_p0", 0, 24'h000010, 16'h0A0A, 1'b1);
        serve("all_p1", 1, 24'h000020, 16'h1B1B, 1'b1);
        serve("all_p2", 2, 24'h000030, 16'h2C2C, 1'b1);

        // Port 2 write; request still high during the p_ack cycle.
        do_reset("wr2");
        set_port(2, 1'b1, 24'h000ABC, 16'h1234, 2'b01);
        a_p_req[2] = 1'b1;
        tick(1);
        check("wr2_req", {a_mem_req, a_mem_we}, 2'b11);
        check("wr2_din", a_mem_din, 16'h1234);
        check("wr2_be", a_mem_be, 2'b01);
        check("wr2_addr", a_mem_addr, 24'h000ABC);
        a_mem_ack = 1'b1;
        tick(1);
        a_mem_ack = 1'b0;
        check("wr2_pack", a_p_ack, 3'b100);
        tick(1);
        check("wr2_no_regrant", {31'b0, a_mem_req}, 0);
        a_p_req[2] = 1'b0;
        tick(1);
        check("wr2_idle", {a_mem_req, a_p_ack}, 0);

        // Reset asserted mid-access.
        do_reset("mid");
        set_port(0, 1'b1, 24'h000055, 16'hAAAA, 2'b11);
        a_p_req[0] = 1'b1;
        tick(1);
        check("mid_req", {a_mem_req, a_mem_we}, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        check("mid_async_mem", {a_mem_req, a_mem_rfsh, a_mem_we, a_mem_be}, 0);
        check("mid_async_addr", {8'h0, a_mem_addr}, 0);
        check("mid_async_din", {16'h0, a_mem_din}, 0);
        a_p_req[0] = 1'b0;
        tick(1);
        reset_n   = 1'b1;
        a_mem_ack = 1'b1;
        tick(1);
        a_mem_ack = 1'b0;
        check("mid_ack_ignored", {a_p_ack, a_mem_req}, 0);
        tick(1);
        check("mid_still_quiet", {a_p_ack, a_mem_req}, 0);
        a_p_req[0] = 1'b1;
        tick(1);
        check("mid_rerequest", {31'b0, a_mem_req}, 1);
        a_mem_ack = 1'b1;
        tick(1);
        a_mem_ack = 1'b0;
        check("mid_rerequest_ack", a_p_ack, 3'b001);
        a_p_req[0] = 1'b0;

        // Short-interval instance: periodic refresh, controller acks next cycle.
        do_reset("rf8");
        first_rfsh = -1; last_rfsh = -1; n_rfsh = 0; n_req = 0; n_both = 0;
        b_prev = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            b_mem_ack = b_prev;
            b_prev    = b_mem_rfsh;
            if (b_mem_req === 1'b1) n_req++;
            if (b_mem_req === 1'b1 && b_mem_rfsh === 1'b1) n_both++;
            if (b_mem_rfsh === 1'b1) begin
                if (first_rfsh < 0) first_rfsh = i;
                else check("rf8_gap", i - last_rfsh, 8);
                last_rfsh = i;
                n_rfsh++;
            end
        end
        b_mem_ack = 1'b0;
        check("rf8_first", first_rfsh, 9);
        check("rf8_count", n_rfsh, 7);
        check("rf8_no_req", n_req, 0);
        check("rf8_no_both", n_both, 0);
        check("rf8_no_pack", b_p_ack, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 24, meaning SDRAM word-address width.
REQ-002 The block SHALL have parameter RFSH_INTERVAL, default 1560, meaning clk_sys cycles between refresh requests.
REQ-003 The block SHALL have port clk_sys  input  1  single system clock; all logic on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port p_req  input  3  per-port level request, held high until p_ack; port 0 video, port 1 ioctl download, port 2 CPU.
REQ-006 The block SHALL have port p_we  input  3  per-port write enable (1 = write), stable while p_req is high.
REQ-007 The block SHALL have port p_addr  input  3xAW  per-port word address.
REQ-008 The block SHALL have port p_din  input  3x16  per-port write data.
REQ-009 The block SHALL have port p_be  input  3x2  per-port byte enables {upper, lower}.
REQ-010 The block SHALL have port p_ack  output  3  one-cycle completion pulse per port.
REQ-011 The block SHALL have port p_dout  output  16  read data shared by all ports, valid while the matching p_ack bit is high.
REQ-012 The block SHALL have port mem_ready  input  1  SDRAM controller idle and able to accept a command.
REQ-013 The block SHALL have ports mem_req and mem_rfsh  output  1 each  one-cycle access or auto-refresh command strobes.
REQ-014 The block SHALL have ports mem_we (1), mem_addr (AW), mem_din (16), mem_be (2)  output  command fields, registered, valid while mem_req is high.
REQ-015 The block SHALL have port mem_ack  input  1  one-cycle completion pulse from the controller, for both access and refresh.
REQ-016 The block SHALL have port mem_dout  input  16  read data, valid while mem_ack is high.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, RFSH.
REQ-018 The block SHALL evaluate in IDLE only when mem_ready=1 and no p_ack bit is high in that cycle; this prevents re-granting a port that is still dropping p_req.
REQ-019 The block SHALL apply priority in this order: pending refresh, then port 0, then ports 1/2 round-robin.
REQ-020 When port 1 and port 2 request together, the block SHALL grant the one not granted last; rr_last SHALL update only on a port 1 or port 2 grant.
REQ-021 When a port is granted, the next cycle SHALL have mem_req=1 for exactly one cycle with the latched command fields, and the state SHALL move to ACCESS.
REQ-022 The block SHALL keep the granted port index latched until completion; a change in p_req while in ACCESS SHALL NOT affect the transaction.
REQ-023 When mem_ack=1 in ACCESS, the next cycle SHALL have p_ack[grant]=1 for one cycle and p_dout=registered mem_dout (reads and writes alike), and the state SHALL move to IDLE.
REQ-024 The refresh counter SHALL count 0..RFSH_INTERVAL-1 and wrap, setting rfsh_pending at wrap.
REQ-025 When refresh is selected, the next cycle SHALL have mem_rfsh=1 for one cycle, the state SHALL move to RFSH, and rfsh_pending SHALL clear.
REQ-026 When mem_ack=1 in RFSH, the state SHALL return to IDLE and no p_ack SHALL be generated.
REQ-027 If a wrap occurs in the same cycle rfsh_pending clears, rfsh_pending SHALL stay set; pending refreshes SHALL NOT accumulate beyond one.
REQ-028 The block SHALL ignore mem_ack in IDLE.
REQ-029 mem_req and mem_rfsh SHALL never both be high.
REQ-030 The minimum latency SHALL be 1 cycle from p_req sampled in IDLE to mem_req, and 1 cycle from mem_ack to p_ack.

Reset
REQ-031 Asserting reset_n low SHALL immediately force state IDLE; p_ack, mem_req, mem_rfsh, mem_we, mem_addr, mem_din, mem_be, and p_dout to 0; the refresh counter to 0; rfsh_pending to 0; rr_last so that port 1 wins first.
REQ-032 After reset mid-transaction, the interrupted transaction SHALL be abandoned without p_ack; the requester re-requests.

Structure
REQ-033 The package sdram_arb_pkg SHALL hold the state enum, the 2-bit port-index type, and the constants NPORTS=3 and the port index names.
REQ-034 The refresh counter and pending flag SHALL be the sub-module sdram_refresh_timer, with ports clk_sys, reset_n, clr, pending.

Verification
REQ-035 Verification SHALL cover this case: port 0 read at addr 0x000100, mem_ack with mem_dout=0xBEEF, 3 cycles later -> mem_req 1 cycle after p_req, p_ack[0] 1 cycle after mem_ack, p_dout=0xBEEF.
REQ-036 Verification SHALL cover this case: ports 1 and 2 held high for 4 transactions -> grant order 1,2,1,2.
REQ-037 Verification SHALL cover this case: all three ports request together with rfsh_pending=1 -> order refresh, port 0, port 1, port 2.
REQ-038 Verification SHALL cover this case: RFSH_INTERVAL=8 with ports idle -> mem_rfsh every 8 cycles (controller acks next cycle); mem_req stays 0.
REQ-039 Verification SHALL cover this case: port 2 write p_din=0x1234, p_be=2'b01 -> mem_we=1, mem_din=0x1234, mem_be=01; port 2 keeps p_req high one cycle after p_ack -> no second mem_req in that cycle.
REQ-040 Verification SHALL cover this case: reset_n pulsed low during ACCESS -> all outputs 0 asynchronously, no p_ack; a later mem_ack is ignored.
